// File: rtl/mipscpu_pkg.sv
// Shared types and defaults for the CPU run/single-step control path.
package mipscpu_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    STEP_IDLE  = 2'b01,
    STEP_PULSE = 2'b10,
    HALTED     = 2'b11
  } step_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_CNT_W           = 20;
  localparam int unsigned DEFAULT_STEP_W          = 16;

  // The CPU advances only in free-running mode or during the single step pulse.
  function automatic logic state_enables_cpu(input step_state_t s);
    return (s == RUN) || (s == STEP_PULSE);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for a bouncing push button.
// The clean level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce
  import mipscpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             clean_prev_q, clean_prev_d;
  logic             b_s;

  assign b_s = sync_q[1];

  always_comb begin
    sync_d       = {sync_q[0], btn_raw};
    clean_d      = clean_q;
    cnt_d        = '0;
    clean_prev_d = clean_q;
    // Any agreeing sample restarts the count, so glitches never accumulate.
    if (b_s != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = b_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_prev_d;
    end
  end

  assign level = clean_q;
  assign rise  = clean_q & ~clean_prev_q;

endmodule

// File: rtl/step_ctrl.sv
// Run/single-step controller driving the CPU-wide advance enable.
// Freezes the core on an exception strobe until the operator presses the button.
module step_ctrl
  import mipscpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W,
  parameter int unsigned STEP_W          = DEFAULT_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              singlestep_sw,
  input  logic              singlestep_btn,
  input  logic              exc_halt,
  output logic              cpu_en,
  output logic              halted,
  output logic [STEP_W-1:0] step_count,
  output logic              btn_clean
);

  step_state_t       state_q, state_d;
  logic [1:0]        sw_sync_q, sw_sync_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic              sw_s;
  logic              press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(singlestep_btn),
    .level  (btn_clean),
    .rise   (press)
  );

  // The mode switch is a slow level, so synchronising is enough.
  assign sw_s = sw_sync_q[1];

  always_comb begin
    sw_sync_d    = {sw_sync_q[0], singlestep_sw};
    state_d      = state_q;
    step_count_d = step_count_q + (cpu_en ? STEP_W'(1) : STEP_W'(0));
    unique case (state_q)
      RUN: begin
        if (exc_halt) begin
          state_d = HALTED;
        end else if (sw_s) begin
          state_d = STEP_IDLE;
        end
      end
      STEP_IDLE: begin
        if (!sw_s) begin
          state_d = RUN;
        end else if (press) begin
          state_d = STEP_PULSE;
        end
      end
      // exc_halt is ignored here: the operator is already stepping.
      STEP_PULSE: state_d = STEP_IDLE;
      HALTED: begin
        if (press) begin
          state_d = sw_s ? STEP_IDLE : RUN;
        end
      end
      default: state_d = STEP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STEP_IDLE;
      sw_sync_q    <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sw_sync_q    <= sw_sync_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_en     = state_enables_cpu(state_q);
  assign halted     = (state_q == HALTED);
  assign step_count = step_count_q;

endmodule
